// File: rtl/event_injector.sv
// Event injector: queues (value, gap) descriptors and replays them as single-cycle
// newX strobes with x valid, spaced by exact clock-tick gaps.
module event_injector #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_W-1:0]          wr_value,
  input  logic [DELAY_W-1:0]         wr_delay,
  output logic [DATA_W-1:0]          x,
  output logic                       newX,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t             state;
  logic [DELAY_W-1:0] cnt;
  logic [DATA_W-1:0]  val;

  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]  mem_value [DEPTH];
  logic [DELAY_W-1:0] mem_delay [DEPTH];

  logic               has_data;
  logic               emit;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  head_value;
  logic [DELAY_W-1:0] head_delay;

  // Handshake: a descriptor transfers on a rising clk edge where wr_valid && wr_ready.
  // wr_ready depends only on en, reset and the registered occupancy, never on a
  // same-cycle pop, so a full queue refuses writes even on the edge that frees a slot.
  assign wr_ready   = rst && en && (count < FULL);
  assign push       = wr_valid && wr_ready;
  assign has_data   = (count != '0);
  assign emit       = en && (state == ST_WAIT) && (cnt == '0);
  assign pop        = has_data && ((en && (state == ST_IDLE)) || emit);
  assign head_value = mem_value[rd_ptr];
  assign head_delay = mem_delay[rd_ptr];

  assign pending = count;
  assign busy    = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_value[wr_ptr] <= wr_value;
      mem_delay[wr_ptr] <= wr_delay;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The emit edge also loads the next descriptor, so queued events are spaced
  // by exactly (next delay + 1) cycles with no idle cycle in between.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      val   <= '0;
      x     <= '0;
      newX  <= 1'b0;
    end else if (!en) begin
      newX <= 1'b0;
    end else begin
      newX <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (has_data) begin
            cnt   <= head_delay;
            val   <= head_value;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - DELAY_W'(1);
          end else begin
            newX <= 1'b1;
            x    <= val;
            if (has_data) begin
              cnt <= head_delay;
              val <= head_value;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
